full_adder_core: RTL and testbench

- Single-clock full adder block: adds two WIDTH-bit operands plus a carry-in.
- Provides a zero-latency combinational result and a one-cycle registered result qualified by a valid strobe.
- Default WIDTH=1 gives the classic 1-bit full adder (a, b, cin -> sum, cout) used as a leaf cell in arithmetic datapaths.
- Wider builds serve as a ripple-carry adder stage.

---
 rtl/full_adder_core.sv | 95 +++++++++
 tb/tb_full_adder_core.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/full_adder_core.sv
// ============================================================================
//  Module   : full_adder_core
//  Purpose  : WIDTH-bit ripple-carry full adder with a combinational result
//             and a one-cycle registered result qualified by out_valid.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module full_adder_slice (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

module full_adder_core #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [WIDTH-1:0] sum_r,
    output logic             cout_r,
    output logic             out_valid
);

    // carry[i] feeds slice i; carry[WIDTH] is the final carry-out
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_r_d;
    logic [WIDTH-1:0] sum_r_q;
    logic             cout_r_d;
    logic             cout_r_q;
    logic             out_valid_d;
    logic             out_valid_q;

    assign carry[0] = cin;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_slice
            full_adder_slice u_slice (
                .a    (a[i]),
                .b    (b[i]),
                .cin  (carry[i]),
                .sum  (sum[i]),
                .cout (carry[i+1])
            );
        end
    endgenerate

    assign cout = carry[WIDTH];

    always_comb begin
        sum_r_d     = sum_r_q;
        cout_r_d    = cout_r_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            sum_r_d     = sum;
            cout_r_d    = cout;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r_q     <= '0;
            cout_r_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_r_q     <= sum_r_d;
            cout_r_q    <= cout_r_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sum_r     = sum_r_q;
    assign cout_r    = cout_r_q;
    assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_full_adder_core.sv
// ============================================================================
//  Module   : tb_full_adder_core
//  Purpose  : Scoreboard bench for full_adder_core at WIDTH=1 and WIDTH=8.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_full_adder_core;

    logic       clk;
    logic       rst_n;

    logic       a1, b1, cin1, in_valid1;
    logic       sum1, cout1, sum_r1, cout_r1, out_valid1;

    logic [7:0] a8, b8, sum8, sum_r8;
    logic       cin8, in_valid8, cout8, cout_r8, out_valid8;

    int         checks;
    int         errors;
    int         cyc;
    int         pulses8;
    int         first8;
    int         last8;
    bit         mon_en;

    logic [1:0] q1[$];
    logic [8:0] q8[$];

    full_adder_core #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
        .in_valid  (in_valid1),
        .sum       (sum1),
        .cout      (cout1),
        .sum_r     (sum_r1),
        .cout_r    (cout_r1),
        .out_valid (out_valid1)
    );

    full_adder_core #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
        .in_valid  (in_valid8),
        .sum       (sum8),
        .cout      (cout8),
        .sum_r     (sum_r8),
        .cout_r    (cout_r8),
        .out_valid (out_valid8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every out_valid pulse must match the oldest pending result
    always @(posedge clk) begin
        #1;
        cyc++;
        if (mon_en) begin
            if (out_valid1) begin
                if (q1.size() == 0) check("w1_unexpected_valid", 1, 0);
                else check("w1_reg_result", {cout_r1, sum_r1}, q1.pop_front());
            end
            if (out_valid8) begin
                if (pulses8 == 0) first8 = cyc;
                last8 = cyc;
                pulses8++;
                if (q8.size() == 0) check("w8_unexpected_valid", 1, 0);
                else check("w8_reg_result", {cout_r8, sum_r8}, q8.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] exp2;
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        pulses8   = 0;
        first8    = 0;
        last8     = 0;
        mon_en    = 1'b0;
        rst_n     = 1'b0;
        a1 = 0; b1 = 0; cin1 = 0; in_valid1 = 0;
        a8 = 0; b8 = 0; cin8 = 0; in_valid8 = 0;
        #1;
        check("rst_sum_r1", sum_r1, 0);
        check("rst_cout_r1", cout_r1, 0);
        check("rst_valid1", out_valid1, 0);
        check("rst_reg8", {out_valid8, cout_r8, sum_r8}, 0);

        // Exhaustive 1-bit truth table, no clock involvement
        for (int i = 0; i < 8; i++) begin
            {a1, b1, cin1} = 3'(i);
            #1;
            exp2 = 2'(i[2]) + 2'(i[1]) + 2'(i[0]);
            check($sformatf("tt_%0d%0d%0d", i[2], i[1], i[0]), {cout1, sum1}, exp2);
        end

        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; #1;
        check("w8_ff_01_0", {cout8, sum8}, 9'h100);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; #1;
        check("w8_ff_ff_1", {cout8, sum8}, 9'h1FF);
        a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; #1;
        check("w8_00_00_0", {cout8, sum8}, 9'h000);

        // Held in reset: captures suppressed while comb path keeps working
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            {a1, b1, cin1} = 3'($urandom_range(0, 7));
            in_valid1 = 1'b1;
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            in_valid8 = 1'b1;
            @(posedge clk);
            #1;
            check("inrst_reg1", {out_valid1, cout_r1, sum_r1}, 0);
            check("inrst_reg8", {out_valid8, cout_r8, sum_r8}, 0);
            check("inrst_comb1", {cout1, sum1}, 2'(a1) + 2'(b1) + 2'(cin1));
        end

        @(negedge clk);
        in_valid1 = 1'b0;
        in_valid8 = 1'b0;
        rst_n     = 1'b1;
        mon_en    = 1'b1;

        // Single 1-bit capture, then hold
        @(negedge clk);
        a1 = 1; b1 = 1; cin1 = 0; in_valid1 = 1'b1;
        q1.push_back(2'b10);
        @(negedge clk);
        in_valid1 = 1'b0;
        a1 = 0; b1 = 0; cin1 = 1;
        @(posedge clk);
        #2;
        check("w1_valid_drop", out_valid1, 0);
        check("w1_hold", {cout_r1, sum_r1}, 2'b10);

        // 8-bit back-to-back stream
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            in_valid8 = 1'b1;
            q8.push_back(9'(a8) + 9'(b8) + 9'(cin8));
        end
        @(negedge clk);
        in_valid8 = 1'b0;
        repeat (3) @(negedge clk);
        check("w8_pulse_count", pulses8, 4);
        check("w8_pulse_span", last8 - first8, 3);
        check("w8_queue_drained", q8.size(), 0);

        // Reset arriving mid-operation clears outputs without a clock edge
        mon_en = 1'b0;
        @(negedge clk);
        a1 = 1; b1 = 1; cin1 = 1; in_valid1 = 1'b1;
        @(posedge clk);
        #1;
        check("mid_captured", {out_valid1, cout_r1, sum_r1}, 3'b111);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_async_clear", {out_valid1, cout_r1, sum_r1}, 0);
        @(posedge clk);
        #1;
        check("mid_held_clear", {out_valid1, cout_r1, sum_r1}, 0);
        @(negedge clk);
        in_valid1 = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_no_pulse", out_valid1, 0);
        check("w1_queue_drained", q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
